jtag_scan_regs: RTL

JTAG_SCAN_REGS -- requirements
Module: jtag_scan_regs

---
 rtl/jtag_pkg.sv | 32 +++
 rtl/jtag_shift_reg.sv | 57 +++++
 rtl/jtag_scan_regs.sv | 122 ++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared JTAG constants: IR width, opcodes, default IDCODE and DR-select decode.
// Latency: n/a (declarations only).
// Backpressure: n/a; imported by the TAP controller and the scan register block.
package jtag_pkg;

    localparam int IR_W = 4;

    localparam logic [IR_W-1:0] OP_IDCODE  = 4'h1;
    localparam logic [IR_W-1:0] OP_USER    = 4'h2;
    localparam logic [IR_W-1:0] OP_BYPASS  = 4'hF;

    // Fixed pattern loaded into the IR shift stage on Capture-IR
    localparam logic [IR_W-1:0] IR_CAPTURE = 4'b0001;

    localparam logic [31:0] IDCODE_DEFAULT = 32'h1234_5677;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_e;

    // Unknown opcodes fall back to BYPASS so TDI always reaches TDO
    function automatic dr_sel_e decode_ir(input logic [IR_W-1:0] ir);
        case (ir)
            OP_IDCODE: decode_ir = DR_IDCODE;
            OP_USER:   decode_ir = DR_USER;
            default:   decode_ir = DR_BYPASS;
        endcase
    endfunction

endpackage

// File: rtl/jtag_shift_reg.sv
// Generic JTAG shift register with optional update (shadow) stage.
// Latency: capture/shift/update each take effect on the next TCLK rising edge.
// Backpressure: none; strobes are pre-prioritised by the parent (tlr > update > capture > shift).
// Ports: clk_i/rst_i clock and async active-high reset; tlr_i sync reload of reset values;
//        capture_i/shift_i/update_i TAP strobes; tdi_i serial in; lsb_o serial out bit;
//        upd_q_o update stage contents.
module jtag_shift_reg #(
    parameter int           W            = 4,
    parameter logic [W-1:0] CAP_VAL      = '0,
    parameter bit           CAP_FROM_UPD = 1'b0,
    parameter logic [W-1:0] SHIFT_RST    = '0,
    parameter logic [W-1:0] UPD_RST      = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         tlr_i,
    input  logic         capture_i,
    input  logic         shift_i,
    input  logic         update_i,
    input  logic         tdi_i,
    output logic         lsb_o,
    output logic [W-1:0] upd_q_o
);

    logic [W-1:0] shift_q, shift_d;
    logic [W-1:0] upd_q, upd_d;

    always_comb begin
        shift_d = shift_q;
        upd_d   = upd_q;
        if (tlr_i) begin
            shift_d = SHIFT_RST;
            upd_d   = UPD_RST;
        end else if (update_i) begin
            upd_d = shift_q;
        end else if (capture_i) begin
            // Read-back registers capture their own shadow stage
            shift_d = CAP_FROM_UPD ? upd_q : CAP_VAL;
        end else if (shift_i) begin
            shift_d = {tdi_i, shift_q[W-1:1]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_q <= SHIFT_RST;
            upd_q   <= UPD_RST;
        end else begin
            shift_q <= shift_d;
            upd_q   <= upd_d;
        end
    end

    assign lsb_o   = shift_q[0];
    assign upd_q_o = upd_q;

endmodule

// File: rtl/jtag_scan_regs.sv
// JTAG instruction register plus IDCODE / USER / BYPASS data registers behind a TAP.
// Latency: TDI-to-TDO is 1 TCLK (BYPASS), 32 (IDCODE) or USER_W (USER); TDO is combinational from flops.
// Backpressure: none; acts on one-hot TAP strobes, priority TLR > Update > Capture > Shift if several assert.
// Ports: TCLK/TRST clock and async active-high reset; TDI/TDO/TDO_en serial data;
//        *_in TAP state strobes; ir_q current instruction; user_dr_q USER shadow register.
module jtag_scan_regs
    import jtag_pkg::*;
#(
    parameter logic [31:0] IDCODE_VAL = IDCODE_DEFAULT,
    parameter int          USER_W     = 8
) (
    input  logic              TCLK,
    input  logic              TRST,
    input  logic              TDI,
    input  logic              Test_Logic_Reset_in,
    input  logic              Capture_IR_in,
    input  logic              Shift_IR_in,
    input  logic              Update_IR_in,
    input  logic              Capture_DR_in,
    input  logic              Shift_DR_in,
    input  logic              Update_DR_in,
    output logic              TDO,
    output logic              TDO_en,
    output logic [IR_W-1:0]   ir_q,
    output logic [USER_W-1:0] user_dr_q
);

    // Strobe arbitration: only the highest-priority strobe acts
    logic tlr, upd_hit, cap_hit;
    logic upd_ir, upd_dr, cap_ir, cap_dr, sh_ir, sh_dr;

    assign tlr     = Test_Logic_Reset_in;
    assign upd_hit = Update_IR_in | Update_DR_in;
    assign cap_hit = Capture_IR_in | Capture_DR_in;
    assign upd_ir  = !tlr && Update_IR_in;
    assign upd_dr  = !tlr && Update_DR_in;
    assign cap_ir  = !tlr && !upd_hit && Capture_IR_in;
    assign cap_dr  = !tlr && !upd_hit && Capture_DR_in;
    assign sh_ir   = !tlr && !upd_hit && !cap_hit && Shift_IR_in;
    assign sh_dr   = !tlr && !upd_hit && !cap_hit && Shift_DR_in;

    // ir_q is registered, so DR selection always uses the instruction in force before any update
    dr_sel_e dr_sel;
    assign dr_sel = decode_ir(ir_q);

    logic ir_lsb, id_lsb, user_lsb;
    logic [31:0] id_upd_unused;

    jtag_shift_reg #(
        .W(IR_W), .CAP_VAL(IR_CAPTURE), .CAP_FROM_UPD(1'b0),
        .SHIFT_RST(IR_CAPTURE), .UPD_RST(OP_IDCODE)
    ) u_ir (
        .clk_i(TCLK), .rst_i(TRST), .tlr_i(tlr),
        .capture_i(cap_ir), .shift_i(sh_ir), .update_i(upd_ir),
        .tdi_i(TDI), .lsb_o(ir_lsb), .upd_q_o(ir_q)
    );

    jtag_shift_reg #(
        .W(32), .CAP_VAL(IDCODE_VAL), .CAP_FROM_UPD(1'b0),
        .SHIFT_RST('0), .UPD_RST('0)
    ) u_idcode (
        .clk_i(TCLK), .rst_i(TRST), .tlr_i(1'b0),
        .capture_i(cap_dr && dr_sel == DR_IDCODE),
        .shift_i(sh_dr && dr_sel == DR_IDCODE),
        .update_i(1'b0),
        .tdi_i(TDI), .lsb_o(id_lsb), .upd_q_o(id_upd_unused)
    );

    // USER shadow survives Test-Logic-Reset, so its tlr input is tied off
    jtag_shift_reg #(
        .W(USER_W), .CAP_VAL('0), .CAP_FROM_UPD(1'b1),
        .SHIFT_RST('0), .UPD_RST('0)
    ) u_user (
        .clk_i(TCLK), .rst_i(TRST), .tlr_i(1'b0),
        .capture_i(cap_dr && dr_sel == DR_USER),
        .shift_i(sh_dr && dr_sel == DR_USER),
        .update_i(upd_dr && dr_sel == DR_USER),
        .tdi_i(TDI), .lsb_o(user_lsb), .upd_q_o(user_dr_q)
    );

    // Single-flop bypass register
    logic byp_q, byp_d;

    always_comb begin
        byp_d = byp_q;
        if (cap_dr && dr_sel == DR_BYPASS) begin
            byp_d = 1'b0;
        end else if (sh_dr && dr_sel == DR_BYPASS) begin
            byp_d = TDI;
        end
    end

    always_ff @(posedge TCLK or posedge TRST) begin
        if (TRST) begin
            byp_q <= 1'b0;
        end else begin
            byp_q <= byp_d;
        end
    end

    // TDO is forced low under TRST so the output is quiet immediately on an abort
    logic tdo_d;

    always_comb begin
        tdo_d = 1'b0;
        if (!TRST) begin
            if (Shift_IR_in) begin
                tdo_d = ir_lsb;
            end else if (Shift_DR_in) begin
                case (dr_sel)
                    DR_IDCODE: tdo_d = id_lsb;
                    DR_USER:   tdo_d = user_lsb;
                    default:   tdo_d = byp_q;
                endcase
            end
        end
    end

    assign TDO    = tdo_d;
    assign TDO_en = !TRST && (Shift_IR_in || Shift_DR_in);

endmodule
